uart_frame_dispatcher: RTL
==========================

Name: uart_frame_dispatcher

Overview:
- Sequences the byte stream coming out of the UART receiver into framed messages and routes each frame's payload to one of NUM_PORTS consumers.
- Frame format on the wire, in order: destination byte, length byte (payload count 0..255), then exactly length payload bytes.
- Sits between uart_receiver (upstream valid/ready) and the command consumers (downstream valid/ready, one lane per port).
- Enforces an inter-byte timeout so that a truncated frame cannot wedge the link.

Parameters:
- NUM_PORTS, 4, number of downstream consumers; legal destination ids are 0..NUM_PORTS-1.
- BAUD_RATE, 9600, line rate; used only to size the timeout.
- CLOCK_FREQUENCY, 100000000, clock frequency in Hz.
- TIMEOUT_BYTES, 4, silence allowed inside a frame, in byte-times. TIMEOUT_CYCLES = TIMEOUT_BYTES*11*CLOCK_FREQUENCY/BAUD_RATE.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- in_data  input  8  byte from uart_receiver.
- in_valid  input  1  in_data holds a byte.
- in_ready  output  1  byte consumed this cycle when in_valid && in_ready.
- out_data  output  8  payload byte, shared by all ports.
- out_valid  output  NUM_PORTS  one-hot; only the addressed port's bit may be high.
- out_ready  input  NUM_PORTS  per-port accept.
- out_last  output  1  current out_data is the final payload byte of the frame.
- dest_error  output  1  one-cycle pulse when a frame's destination id is >= NUM_PORTS.
- timeout_error  output  1  one-cycle pulse when a frame is aborted by timeout.

Behaviour:
- Reset values: out_valid=0, out_last=0, dest_error=0, timeout_error=0, in_ready=0. State is IDLE, all counters are 0.
- State machine (registered state; handshake outputs are combinational from state and inputs):
  - IDLE: in_ready=1. On accept, latch dest=in_data. Go to LENGTH.
  - LENGTH: in_ready=1. On accept, latch remaining=in_data.
    - remaining==0: go to IDLE with no output. A bad dest with length 0 still pulses dest_error.
    - Else if dest < NUM_PORTS: go to PAYLOAD.
    - Else: pulse dest_error (registered, the cycle after accept) and go to DROP.
  - PAYLOAD: pass-through with zero latency.
    - out_data=in_data; out_valid[dest]=in_valid; in_ready=out_ready[dest]; out_last=(remaining==1).
    - On each handshake, decrement remaining. At remaining 1->0, go to IDLE.
  - DROP: in_ready=1. Accept and discard bytes, decrementing remaining. At 0, go to IDLE.
- Non-addressed out_valid bits are always 0. out_data is don't-care when no out_valid bit is high.
- Timeout:
  - The counter clears on every accepted byte and holds at 0 in IDLE.
  - In PAYLOAD it freezes while in_valid && !out_ready[dest], since that stall belongs to the downstream consumer.
  - Otherwise it increments each cycle. On reaching TIMEOUT_CYCLES-1 in LENGTH, PAYLOAD or DROP: next state is IDLE and timeout_error pulses for one cycle.
  - A partially delivered frame ends without out_last; consumers must use timeout_error to discard it.
- Simultaneous events: if a byte is accepted in the same cycle the timeout would fire, the accept wins and the counter clears.
- Backpressure: a downstream stall holds the upstream byte. The receiver ignores new start bits while it is valid, so a stall longer than one byte-time loses line data. This is accepted behaviour and is not detected.
- Width rules: remaining is 8 bits. dest is 8 bits and is compared as unsigned against NUM_PORTS. The timeout counter is $clog2(TIMEOUT_CYCLES+1) bits.
- Reset asserted mid-frame returns to IDLE on the next edge. No error pulse is generated.

Decomposition:
- Shared package uart_frame_pkg holds:
  - state encoding (IDLE, LENGTH, PAYLOAD, DROP);
  - FRAME_LENGTH_BITS=8, FRAME_DEST_BITS=8, UART_BITS_PER_BYTE=11;
  - the TIMEOUT_CYCLES formula.
- One natural sub-module, uart_frame_timeout: a counter with clear, hold and enable inputs and a single-cycle expired output. The FSM and routing logic stay in the top module.

Test Plan:
- Bytes 0x02,0x03,0xAA,0xBB,0xCC with all out_ready=1 -> out_valid=4'b0100 for three handshakes; out_data sequence AA,BB,CC; out_last high only on CC; state returns to IDLE.
- Bytes 0x01,0x00 -> no out_valid asserted, no error pulses; next frame 0x00,0x01,0x55 is delivered on port 0.
- Bytes 0x07,0x02,0x11,0x22 with NUM_PORTS=4 -> dest_error pulses exactly once; out_valid stays 0; both payload bytes are accepted (in_ready=1); the following frame is routed correctly.
- Frame 0x03,0x02,0x10, then out_ready[3]=0 held for 50 cycles with 0x20 pending -> in_ready=0, out_valid[3]=1 held stable, no timeout; on release 0x20 is delivered with out_last=1.
- Bytes 0x01,0x05,0x01, then silence -> timeout_error pulses exactly TIMEOUT_CYCLES-1 cycles after the last accept; state returns to IDLE; the next byte is treated as a destination.
- reset asserted during PAYLOAD (remaining=3) -> all out_valid=0 and in_ready=0 the next cycle; after reset releases, a new frame is routed normally with no error pulse.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared types and sizing helpers for the UART frame dispatcher.
package uart_frame_pkg;

  localparam int unsigned FRAME_LENGTH_BITS  = 8;
  localparam int unsigned FRAME_DEST_BITS    = 8;
  localparam int unsigned UART_BITS_PER_BYTE = 11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LENGTH,
    ST_PAYLOAD,
    ST_DROP
  } frame_state_e;

  // Inter-byte silence budget in clock cycles; 64-bit math so 100 MHz clocks do not overflow.
  function automatic int unsigned timeout_cycles(input int unsigned bytes,
                                                 input int unsigned clk_hz,
                                                 input int unsigned baud);
    longint unsigned num;
    num = 64'(bytes) * 64'(UART_BITS_PER_BYTE) * 64'(clk_hz);
    return 32'(num / 64'(baud));
  endfunction

endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte silence counter: clears on accept, freezes on hold, flags the cycle it reaches its limit.
module uart_frame_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 44
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic hold_i,
  input  logic enable_i,
  output logic expired_c_o
);

  localparam int unsigned CNT_BITS = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_BITS-1:0] FIRE_AT = CNT_BITS'(TIMEOUT_CYCLES - 2);

  logic [CNT_BITS-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i || !enable_i) begin
      count_d = '0;
    end else if (!hold_i) begin
      count_d = count_q + CNT_BITS'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // High in the cycle whose edge moves the count onto TIMEOUT_CYCLES-1.
  assign expired_c_o = enable_i && !clear_i && !hold_i && (count_q == FIRE_AT);

endmodule

// File: rtl/uart_frame_dispatcher.sv
// Splits the UART byte stream into dest/length/payload frames and routes payload to one of NUM_PORTS lanes.
module uart_frame_dispatcher
  import uart_frame_pkg::*;
#(
  parameter int unsigned NUM_PORTS       = 4,
  parameter int unsigned BAUD_RATE       = 9600,
  parameter int unsigned CLOCK_FREQUENCY = 100000000,
  parameter int unsigned TIMEOUT_BYTES   = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [7:0]           out_data,
  output logic [NUM_PORTS-1:0] out_valid,
  input  logic [NUM_PORTS-1:0] out_ready,
  output logic                 out_last,
  output logic                 dest_error,
  output logic                 timeout_error
);

  localparam int unsigned TIMEOUT_CYCLES =
    timeout_cycles(TIMEOUT_BYTES, CLOCK_FREQUENCY, BAUD_RATE);

  frame_state_e                 state_q, state_d;
  logic [FRAME_DEST_BITS-1:0]   dest_q, dest_d;
  logic [FRAME_LENGTH_BITS-1:0] remaining_q, remaining_d;
  logic                         dest_error_q, dest_error_d;
  logic                         timeout_error_q, timeout_error_d;

  logic [NUM_PORTS-1:0] sel_mask;
  logic                 sel_ready;
  logic                 in_payload;
  logic                 accept;
  logic                 dest_bad;
  logic                 stall_hold;
  logic                 expired;

  always_comb begin
    sel_mask = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      sel_mask[p] = (32'(dest_q) == p);
    end
  end

  assign sel_ready  = |(out_ready & sel_mask);
  assign in_payload = (state_q == ST_PAYLOAD);
  assign dest_bad   = (32'(dest_q) >= NUM_PORTS);

  // Zero-latency pass-through in PAYLOAD; handshakes are masked while reset is held.
  assign in_ready   = !reset && (in_payload ? sel_ready : 1'b1);
  assign out_valid  = (!reset && in_payload && in_valid) ? sel_mask : '0;
  assign out_last   = !reset && in_payload && (remaining_q == FRAME_LENGTH_BITS'(1));
  assign out_data   = in_data;
  assign accept     = in_valid && in_ready;

  // A downstream stall is not line silence, so it must not age the timeout.
  assign stall_hold = in_payload && in_valid && !sel_ready;

  uart_frame_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock      (clock),
    .reset      (reset),
    .clear_i    (accept),
    .hold_i     (stall_hold),
    .enable_i   (state_q != ST_IDLE),
    .expired_c_o(expired)
  );

  always_comb begin
    state_d         = state_q;
    dest_d          = dest_q;
    remaining_d     = remaining_q;
    dest_error_d    = 1'b0;
    timeout_error_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          dest_d  = in_data;
          state_d = ST_LENGTH;
        end
      end
      ST_LENGTH: begin
        if (accept) begin
          remaining_d = in_data;
          if (in_data == 8'h00) begin
            state_d      = ST_IDLE;
            dest_error_d = dest_bad;
          end else if (!dest_bad) begin
            state_d = ST_PAYLOAD;
          end else begin
            state_d      = ST_DROP;
            dest_error_d = 1'b1;
          end
        end else if (expired) begin
          state_d         = ST_IDLE;
          timeout_error_d = 1'b1;
        end
      end
      ST_PAYLOAD, ST_DROP: begin
        if (accept) begin
          remaining_d = remaining_q - FRAME_LENGTH_BITS'(1);
          if (remaining_q == FRAME_LENGTH_BITS'(1)) begin
            state_d = ST_IDLE;
          end
        end else if (expired) begin
          state_d         = ST_IDLE;
          timeout_error_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      dest_q          <= '0;
      remaining_q     <= '0;
      dest_error_q    <= 1'b0;
      timeout_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      dest_q          <= dest_d;
      remaining_q     <= remaining_d;
      dest_error_q    <= dest_error_d;
      timeout_error_q <= timeout_error_d;
    end
  end

  assign dest_error    = dest_error_q;
  assign timeout_error = timeout_error_q;

endmodule
